soc_bus_fabric: RTL and testbench



---
 rtl/soc_bus_pkg.sv | 18 +
 rtl/soc_bus_decode.sv | 31 +++
 rtl/soc_bus_fabric.sv | 127 ++++++++++++
 tb/tb_soc_bus_fabric.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the CPU-to-target memory-mapped bus fabric.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int          ERR_CNT_W         = 16;

  function automatic int dec_width(input int dec_lsb);
    return 32 - dec_lsb;
  endfunction

endpackage

// File: rtl/soc_bus_decode.sv
// Combinational address decoder: compares the decode field against every
// target base and reports a hit plus the lowest matching target index.
module soc_bus_decode
  import soc_bus_pkg::*;
#(
  parameter int N_TARGETS = 4,
  parameter int FIELD_W   = 8,
  parameter int IDX_W     = 2
) (
  input  logic [FIELD_W-1:0]           field,
  input  logic [N_TARGETS*FIELD_W-1:0] target_base,
  output logic                         hit,
  output logic [IDX_W-1:0]             sel_idx
);

  logic [N_TARGETS-1:0] match;

  for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_match
    assign match[gi] = (field == target_base[gi*FIELD_W +: FIELD_W]);
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit     = |match;
    sel_idx = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (match[i]) sel_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// picorv32 native-port interconnect: decode, fixed or handshake ready,
// bus timeout and error response/logging for unmapped or hung accesses.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                                       N_TARGETS      = 4,
  parameter int                                       DEC_LSB        = 24,
  parameter logic [N_TARGETS*dec_width(DEC_LSB)-1:0]  TARGET_BASE    = {8'hff, 8'hfe, 8'h01, 8'h00},
  parameter logic [N_TARGETS-1:0]                     FIXED_LAT      = 4'b1110,
  parameter int                                       TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]                              ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    m_valid,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  input  logic [3:0]              m_wstrb,
  output logic                    m_ready,
  output logic [31:0]             m_rdata,
  output logic [N_TARGETS-1:0]    t_valid,
  output logic [N_TARGETS-1:0]    t_we,
  output logic [DEC_LSB-1:0]      t_addr,
  output logic [31:0]             t_wdata,
  output logic [3:0]              t_wstrb,
  input  logic [N_TARGETS*32-1:0] t_rdata,
  input  logic [N_TARGETS-1:0]    t_ready,
  output logic                    err_pulse,
  output logic [31:0]             err_addr,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int FIELD_W = dec_width(DEC_LSB);
  localparam int IDX_W   = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       sel_reg;
  logic [TO_W-1:0]        to_cnt_reg;
  logic [31:0]            err_addr_reg;
  logic [ERR_CNT_W-1:0]   err_count_reg;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic                   sel_ready;
  logic [31:0]            rdata_arr [N_TARGETS];

  soc_bus_decode #(
    .N_TARGETS (N_TARGETS),
    .FIELD_W   (FIELD_W),
    .IDX_W     (IDX_W)
  ) u_decode (
    .field       (m_addr[31:DEC_LSB]),
    .target_base (TARGET_BASE),
    .hit         (dec_hit),
    .sel_idx     (dec_idx)
  );

  for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_rdata
    assign rdata_arr[gi] = t_rdata[gi*32 +: 32];
  end

  assign t_addr    = m_addr[DEC_LSB-1:0];
  assign t_wdata   = m_wdata;
  assign t_wstrb   = m_wstrb;
  assign t_we      = t_valid & {N_TARGETS{|m_wstrb}};
  assign err_addr  = err_addr_reg;
  assign err_count = err_count_reg;

  always_comb begin
    state_next = state_reg;
    m_ready    = 1'b0;
    m_rdata    = '0;
    t_valid    = '0;
    err_pulse  = 1'b0;
    sel_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (m_valid) state_next = dec_hit ? ACCESS : ERR;
      end
      ACCESS: begin
        t_valid   = N_TARGETS'(1) << sel_reg;
        m_rdata   = rdata_arr[sel_reg];
        sel_ready = FIXED_LAT[sel_reg] | t_ready[sel_reg];
        // A CPU that withdraws its request mid-access gets no response.
        if (!m_valid) begin
          state_next = IDLE;
        end else begin
          m_ready = sel_ready;
          if (sel_ready)                  state_next = DONE;
          else if (to_cnt_reg == TO_LAST) state_next = ERR;
        end
      end
      ERR: begin
        m_ready    = 1'b1;
        m_rdata    = ERR_RDATA;
        err_pulse  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      to_cnt_reg    <= '0;
      err_addr_reg  <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && m_valid && dec_hit) sel_reg <= dec_idx;
      if (state_reg == ACCESS) to_cnt_reg <= to_cnt_reg + TO_W'(1);
      else                     to_cnt_reg <= '0;
      if (state_reg == ERR) begin
        err_addr_reg <= m_addr;
        if (err_count_reg != '1) err_count_reg <= err_count_reg + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Self-checking bench for soc_bus_fabric: directed vector table, hand-written
// reset/overlap sequences and randomized traffic against a reference model.
module tb_soc_bus_fabric;

  localparam int T_OUT = 16;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         m_valid = 1'b0;
  logic [31:0]  m_addr = '0;
  logic [31:0]  m_wdata = '0;
  logic [3:0]   m_wstrb = '0;
  logic [3:0]   t_ready = '0;
  logic [127:0] t_rdata;

  logic         m_ready, err_pulse;
  logic [31:0]  m_rdata, err_addr, t_wdata;
  logic [3:0]   t_valid, t_we, t_wstrb;
  logic [23:0]  t_addr;
  logic [15:0]  err_count;

  logic         ov_m_ready, ov_err_pulse;
  logic [31:0]  ov_m_rdata, ov_err_addr, ov_t_wdata;
  logic [3:0]   ov_t_valid, ov_t_we, ov_t_wstrb;
  logic [23:0]  ov_t_addr;
  logic [15:0]  ov_err_count;

  always #5 clk = ~clk;

  soc_bus_fabric #(.TIMEOUT_CYCLES(T_OUT)) dut (
    .clk(clk), .n_reset(n_reset), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
    .t_valid(t_valid), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .t_wstrb(t_wstrb), .t_rdata(t_rdata), .t_ready(t_ready),
    .err_pulse(err_pulse), .err_addr(err_addr), .err_count(err_count)
  );

  // Second instance with targets 0 and 2 sharing base 8'h01.
  soc_bus_fabric #(
    .TIMEOUT_CYCLES(T_OUT),
    .TARGET_BASE({8'hff, 8'h01, 8'hfe, 8'h01})
  ) dut_ov (
    .clk(clk), .n_reset(n_reset), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(ov_m_ready), .m_rdata(ov_m_rdata),
    .t_valid(ov_t_valid), .t_we(ov_t_we), .t_addr(ov_t_addr), .t_wdata(ov_t_wdata),
    .t_wstrb(ov_t_wstrb), .t_rdata(t_rdata), .t_ready(t_ready),
    .err_pulse(ov_err_pulse), .err_addr(ov_err_addr), .err_count(ov_err_count)
  );

  // Target environment: synchronous-read RAM on target 1, constants on 2/3.
  logic [31:0] ram [16] = '{default: 32'h0};
  logic [31:0] ram_q = '0;
  logic [31:0] hs_data = '0;
  assign t_rdata = {32'hA5A5_0003, 32'hA5A5_0002, ram_q, hs_data};

  always @(posedge clk) begin
    if (t_we[1])
      for (int b = 0; b < 4; b++)
        if (t_wstrb[b]) ram[t_addr[5:2]][8*b +: 8] <= t_wdata[8*b +: 8];
    ram_q <= ram[t_addr[5:2]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One transfer; delay<0 means t_ready[0] never pulses, else it pulses in
  // ACCESS cycle delay+1. Non-selected ready lines are toggled randomly.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input int delay, input logic [31:0] hsd,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_tv, input logic [15:0] exp_cnt,
                         input logic [31:0] exp_eaddr);
    int lat;
    logic [31:0] rd;
    logic ep;
    logic [3:0] tv, twe;
    lat = 0; rd = '0; ep = 1'b0; tv = '0; twe = '0;
    next_cycle();
    m_valid = 1'b1; m_addr = addr; m_wstrb = wstrb; m_wdata = wdata; hs_data = hsd;
    t_ready = '0;
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      next_cycle();
      t_ready[3:1] = 3'($urandom);
      t_ready[0]   = (delay >= 0 && cyc == delay + 1);
      #1;
      if (m_ready) begin
        lat = cyc; rd = m_rdata; ep = err_pulse; tv = t_valid; twe = t_we;
      end
    end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " rdata"}, rd, exp_rdata);
    chk({name, " err_pulse"}, {31'd0, ep}, {31'd0, exp_err});
    chk({name, " t_valid"}, {28'd0, tv}, {28'd0, exp_tv});
    chk({name, " t_we"}, {28'd0, twe}, {28'd0, exp_tv & {4{|wstrb}}});
    next_cycle();
    m_valid = 1'b0; m_wstrb = '0; t_ready = '0;
    #1;
    chk({name, " bubble m_ready"}, {31'd0, m_ready}, 32'd0);
    chk({name, " bubble t_valid/err"}, {27'd0, err_pulse, t_valid}, 32'd0);
    chk({name, " bubble m_rdata"}, m_rdata, 32'd0);
    chk({name, " err_count"}, {16'd0, err_count}, {16'd0, exp_cnt});
    chk({name, " err_addr"}, err_addr, exp_eaddr);
    $display("txn %s addr=%h wstrb=%h lat=%0d rdata=%h err=%0b cnt=%0d",
             name, addr, wstrb, lat, rd, ep, err_count);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] hsd;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  tv;
    logic [15:0] cnt;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs [8];

  // Reference model state for randomized traffic.
  logic [31:0] model_mem [int];
  logic [7:0]  base_tab [4] = '{8'h00, 8'h01, 8'hfe, 8'hff};
  logic        fixed_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] m_cnt;
  logic [31:0] m_eaddr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0100_0010, 4'hF, 32'h1234_5678, -1, 32'h0, 1, 32'h0, 1'b0, 4'b0010, 16'd0, 32'h0};
    vecs[1] = '{32'h0100_0010, 4'h0, 32'h0, -1, 32'h0, 1, 32'h1234_5678, 1'b0, 4'b0010, 16'd0, 32'h0};
    vecs[2] = '{32'h0000_0040, 4'h0, 32'h0, 5, 32'h5EED_0040, 6, 32'h5EED_0040, 1'b0, 4'b0001, 16'd0, 32'h0};
    vecs[3] = '{32'h8000_0000, 4'h0, 32'h0, -1, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 4'b0000, 16'd1, 32'h8000_0000};
    vecs[4] = '{32'h0000_0044, 4'h0, 32'h0, T_OUT, 32'h1111_2222, T_OUT + 1, 32'hDEAD_BEEF, 1'b1, 4'b0000, 16'd2, 32'h0000_0044};
    vecs[5] = '{32'hFF00_0008, 4'h0, 32'h0, -1, 32'h0, 1, 32'hA5A5_0003, 1'b0, 4'b1000, 16'd2, 32'h0000_0044};
    vecs[6] = '{32'hFE00_0100, 4'h3, 32'hCAFE_0001, -1, 32'h0, 1, 32'hA5A5_0002, 1'b0, 4'b0100, 16'd2, 32'h0000_0044};
    vecs[7] = '{32'h0000_0080, 4'hF, 32'h7777_8888, 0, 32'h0ABC_0080, 1, 32'h0ABC_0080, 1'b0, 4'b0001, 16'd2, 32'h0000_0044};

    // Reset state.
    #2;
    chk("reset m_ready/err_pulse", {30'd0, m_ready, err_pulse}, 32'd0);
    chk("reset t_valid", {28'd0, t_valid}, 32'd0);
    chk("reset m_rdata", m_rdata, 32'd0);
    chk("reset err_addr", err_addr, 32'd0);
    chk("reset err_count", {16'd0, err_count}, 32'd0);
    next_cycle();
    next_cycle();
    n_reset = 1'b1;

    // Overlapping bases: lowest index wins in dut_ov.
    next_cycle();
    m_valid = 1'b1; m_addr = 32'h0100_0000; m_wstrb = 4'h0; m_wdata = 32'h0; hs_data = 32'h0B0B_0B0B;
    next_cycle();
    #1;
    chk("overlap ov t_valid", {28'd0, ov_t_valid}, 32'h1);
    chk("overlap ov m_ready", {31'd0, ov_m_ready}, 32'd0);
    chk("overlap ov m_rdata", ov_m_rdata, 32'h0B0B_0B0B);
    chk("overlap ov t_we/wstrb", {24'd0, ov_t_we, ov_t_wstrb}, 32'd0);
    chk("overlap ov t_addr", {8'd0, ov_t_addr}, 32'd0);
    chk("overlap ov t_wdata", ov_t_wdata, 32'd0);
    chk("overlap main t_valid", {28'd0, t_valid}, 32'h2);
    chk("overlap main m_ready", {31'd0, m_ready}, 32'h1);
    $display("txn overlap addr=01000000 ov_t_valid=%b main_t_valid=%b", ov_t_valid, t_valid);
    next_cycle();
    m_valid = 1'b0;
    next_cycle();
    chk("abort ov t_valid/err_pulse", {27'd0, ov_err_pulse, ov_t_valid}, 32'd0);
    chk("abort ov err log", {ov_err_count, ov_err_addr[15:0]}, 32'd0);

    // Directed vectors.
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wstrb, vecs[i].wdata,
              vecs[i].delay, vecs[i].hsd, vecs[i].lat, vecs[i].rdata, vecs[i].err,
              vecs[i].tv, vecs[i].cnt, vecs[i].eaddr);

    // Reset during handshake wait cycle 3.
    next_cycle();
    m_valid = 1'b1; m_addr = 32'h0000_0040; m_wstrb = 4'h0; t_ready = '0;
    repeat (3) next_cycle();
    #1;
    chk("rst_mid pre t_valid", {28'd0, t_valid}, 32'h1);
    n_reset = 1'b0;
    #1;
    chk("rst_mid t_valid", {28'd0, t_valid}, 32'd0);
    chk("rst_mid m_ready", {31'd0, m_ready}, 32'd0);
    chk("rst_mid err_count", {16'd0, err_count}, 32'd0);
    $display("txn reset_mid addr=00000040 t_valid=%b err_count=%0d", t_valid, err_count);
    m_valid = 1'b0;
    next_cycle();
    n_reset = 1'b1;
    run_txn("post_rst", 32'hFE00_0000, 4'h0, 32'h0, -1, 32'h0, 1, 32'hA5A5_0002,
            1'b0, 4'b0100, 16'd0, 32'h0);

    // Randomized traffic against the reference model.
    m_cnt = 16'd0;
    m_eaddr = 32'h0;
    model_mem[4] = 32'h1234_5678;
    for (int n = 0; n < 40; n++) begin
      int kind, delay, tgt, lat, idx;
      logic [31:0] addr, wdata, hsd, rdata, cur;
      logic [3:0]  wstrb, tv;
      logic [7:0]  top;
      logic        err;
      kind  = $urandom_range(0, 4);
      wdata = $urandom;
      hsd   = $urandom;
      wstrb = 4'($urandom);
      delay = -1;
      case (kind)
        0: addr = 32'h0100_0000 | (32'($urandom_range(0, 15)) << 2);
        1: addr = {($urandom_range(0, 1) == 0) ? 8'hfe : 8'hff, 24'($urandom)};
        2: begin addr = {8'h00, 24'($urandom)}; delay = $urandom_range(0, 18); end
        3: begin
          do top = 8'($urandom); while (top == 8'h00 || top == 8'h01 || top == 8'hfe || top == 8'hff);
          addr = {top, 24'($urandom)};
        end
        default: begin addr = 32'h0100_0000 | (32'($urandom_range(0, 15)) << 2); wstrb = 4'h0; end
      endcase
      tgt = -1;
      for (int i = 0; i < 4; i++)
        if (tgt < 0 && addr[31:24] == base_tab[i]) tgt = i;
      idx = int'(addr[5:2]);
      err = 1'b0; tv = 4'b0; rdata = 32'hDEAD_BEEF; lat = 1;
      if (tgt < 0) begin
        err = 1'b1;
      end else if (fixed_tab[tgt]) begin
        tv = 4'b0001 << tgt;
        cur = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        rdata = (tgt == 1) ? cur : (tgt == 2) ? 32'hA5A5_0002 : 32'hA5A5_0003;
        if (tgt == 1) begin
          for (int b = 0; b < 4; b++) if (wstrb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
          model_mem[idx] = cur;
        end
      end else if (delay + 1 <= T_OUT) begin
        lat = delay + 1; rdata = hsd; tv = 4'b0001;
      end else begin
        lat = T_OUT + 1; err = 1'b1;
      end
      if (err) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_eaddr = addr;
      end
      run_txn($sformatf("rnd%0d", n), addr, wstrb, wdata, delay, hsd, lat, rdata, err,
              tv, m_cnt, m_eaddr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
